fpu_dmem_master: RTL

FPU_DMEM_MASTER -- requirements
Module: fpu_dmem_master

---
 rtl/fpu_dmem_master.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/fpu_dmem_master.sv
// fpu_dmem_master
//   Runs one FPU operation on a memory-mapped FPU over a single-outstanding
//   request/response bus: writes both operands and the start/opcode word,
//   polls STATUS until done (bounded by POLL_MAX), reads RESULT, then
//   presents the result with a one-cycle strobe.
//
// Ports
//   mclk, rst            clock, synchronous active-high reset
//   op_val/op_rdy        operation handshake; op_cmd, op_din1, op_din2 payload
//   res_val              one-cycle result strobe
//   res_data, res_err    result word and error/timeout flag (held between strobes)
//   dmem_req/ack         request phase handshake (addr/cmd/wdata valid with req)
//   dmem_cmd, dmem_width 1=write/0=read, access width (always word)
//   dmem_addr/wdata      register address and write data
//   dmem_rdata/resp      read data and response code (00 wait, 01 ok, 10 error)
//   idle                 high only while waiting for an operation
module fpu_dmem_master #(
  parameter int unsigned POLL_MAX = 255
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic        op_val,
  output logic        op_rdy,
  input  logic [3:0]  op_cmd,
  input  logic [31:0] op_din1,
  input  logic [31:0] op_din2,
  output logic        res_val,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic        dmem_req,
  output logic        dmem_cmd,
  output logic [1:0]  dmem_width,
  output logic [4:0]  dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_req_ack,
  input  logic [31:0] dmem_rdata,
  input  logic [1:0]  dmem_resp,
  output logic        idle
);

  localparam int CW = $clog2(POLL_MAX + 1);

  localparam logic [4:0] ADDR_DIN1   = 5'h00;
  localparam logic [4:0] ADDR_DIN2   = 5'h04;
  localparam logic [4:0] ADDR_CTRL   = 5'h08;
  localparam logic [4:0] ADDR_RESULT = 5'h0C;
  localparam logic [4:0] ADDR_STATUS = 5'h10;

  localparam logic [1:0] RESP_WAIT = 2'b00;
  localparam logic [1:0] RESP_OK   = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_D1, S_WR_D2, S_WR_CTRL, S_RD_STAT, S_RD_RES, S_DONE
  } state_t;

  state_t          state, state_nx;
  logic            rsp_phase, rsp_nx;   // 0: REQ phase, 1: RSP phase
  logic [3:0]      cmd_q;
  logic [31:0]     din1_q, din2_q;
  logic [CW-1:0]   poll_cnt, cnt_inc;
  logic            capture, poll_inc, fin_ok, fin_err;

  assign capture = op_val && (state == S_IDLE);
  assign cnt_inc = poll_cnt + CW'(1);

  // State register
  always_ff @(posedge mclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    if (rst) begin
      state     <= S_IDLE;
      rsp_phase <= 1'b0;
    end else begin
      state     <= state_nx;
      rsp_phase <= rsp_nx;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves a value unassigned (which would infer a latch).
    state_nx = state;
    rsp_nx   = rsp_phase;
    poll_inc = 1'b0;
    fin_ok   = 1'b0;
    fin_err  = 1'b0;
    case (state)
      S_IDLE: if (op_val) begin
        state_nx = S_WR_D1;
        rsp_nx   = 1'b0;
      end
      S_DONE: state_nx = S_IDLE;
      default: begin
        if (!rsp_phase) begin
          // Responses seen before the ack belong to nothing we issued.
          if (dmem_req_ack) rsp_nx = 1'b1;
        end else if (dmem_resp != RESP_WAIT) begin
          rsp_nx = 1'b0;
          if (dmem_resp != RESP_OK) begin
            // Error (and the undefined code 11) aborts the whole sequence.
            state_nx = S_DONE;
            fin_err  = 1'b1;
          end else begin
            case (state)
              S_WR_D1:   state_nx = S_WR_D2;
              S_WR_D2:   state_nx = S_WR_CTRL;
              S_WR_CTRL: state_nx = S_RD_STAT;
              S_RD_STAT: begin
                if (dmem_rdata[0]) begin
                  state_nx = S_RD_RES;
                end else if (cnt_inc == CW'(POLL_MAX)) begin
                  state_nx = S_DONE;
                  fin_err  = 1'b1;
                end else begin
                  poll_inc = 1'b1;
                end
              end
              S_RD_RES: begin
                state_nx = S_DONE;
                fin_ok   = 1'b1;
              end
              default: state_nx = S_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  // Outputs: bus fields are driven only in the REQ phase, so they are
  // stable from request to ack and zero otherwise.
  always_comb begin
    idle       = (state == S_IDLE);
    op_rdy     = idle;
    res_val    = (state == S_DONE);
    dmem_width = 2'b10;
    dmem_req   = 1'b0;
    dmem_cmd   = 1'b0;
    dmem_addr  = 5'h00;
    dmem_wdata = 32'h0;
    if (!rsp_phase) begin
      case (state)
        S_WR_D1:   begin dmem_req = 1'b1; dmem_cmd = 1'b1; dmem_addr = ADDR_DIN1; dmem_wdata = din1_q; end
        S_WR_D2:   begin dmem_req = 1'b1; dmem_cmd = 1'b1; dmem_addr = ADDR_DIN2; dmem_wdata = din2_q; end
        S_WR_CTRL: begin dmem_req = 1'b1; dmem_cmd = 1'b1; dmem_addr = ADDR_CTRL;
                         dmem_wdata = {1'b1, 27'b0, cmd_q}; end
        S_RD_STAT: begin dmem_req = 1'b1; dmem_addr = ADDR_STATUS; end
        S_RD_RES:  begin dmem_req = 1'b1; dmem_addr = ADDR_RESULT; end
        default:   ;
      endcase
    end
  end

  // Operand capture, poll counter and result registers
  always_ff @(posedge mclk) begin
    // NOTE: everything here is a small register, so all of it is reset;
    // there is no memory array whose reset would cost a clear sequence.
    if (rst) begin
      cmd_q    <= 4'h0;
      din1_q   <= 32'h0;
      din2_q   <= 32'h0;
      poll_cnt <= '0;
      res_data <= 32'h0;
      res_err  <= 1'b0;
    end else begin
      if (capture) begin
        cmd_q    <= op_cmd;
        din1_q   <= op_din1;
        din2_q   <= op_din2;
        poll_cnt <= '0;
      end else if (poll_inc) begin
        poll_cnt <= cnt_inc;
      end
      if (fin_ok) begin
        res_data <= dmem_rdata;
        res_err  <= 1'b0;
      end else if (fin_err) begin
        res_data <= 32'h0;
        res_err  <= 1'b1;
      end
    end
  end

endmodule
